// File: rtl/sram64kb_pkg.sv
// Shared parameters, FSM states and bank decode for the 64 KB SRAM controller.
package sram64kb_pkg;
  localparam int NBANK   = 64;
  localparam int BANK_AW = 10;
  localparam int DW      = 8;
  localparam int BW      = $clog2(NBANK);
  localparam int AW      = BANK_AW + BW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  function automatic logic [NBANK-1:0] bank_sel_n(
    input logic [BW-1:0] bank
  );
    logic [NBANK-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return ~(one << bank);
  endfunction
endpackage

// File: rtl/sram64kb_rr_arb.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is taken.
module sram64kb_rr_arb (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt,
  output logic       id
);
  logic last_q;
  logic last_d;
  logic win;

  always_comb begin
    if (req == 2'b11) win = ~last_q;
    else              win = req[1];
    gnt    = '0;
    last_d = last_q;
    if (adv && |req) begin
      gnt[win] = 1'b1;
      last_d   = win;
    end
  end

  // Starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  assign id = win;
endmodule

// File: rtl/sram64kb_ctrl.sv
// Two-port request controller for the 64-bank SRAM array:
// arbitrates, decodes bank selects and sequences setup/strobe/hold/done.
module sram64kb_ctrl
  import sram64kb_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0,
  input  logic               REQ1,
  input  logic               WE0,
  input  logic               WE1,
  input  logic [AW-1:0]      ADDR0,
  input  logic [AW-1:0]      ADDR1,
  input  logic [DW-1:0]      WDATA0,
  input  logic [DW-1:0]      WDATA1,
  output logic               GNT0,
  output logic               GNT1,
  output logic               DONE0,
  output logic               DONE1,
  output logic [DW-1:0]      RDATA,
  output logic               BUSY,
  output logic [BANK_AW-1:0] MEM_ADDR,
  output logic               MEM_CE,
  output logic               MEM_WEB,
  output logic [NBANK-1:0]   MEM_OEB,
  output logic [NBANK-1:0]   MEM_CSB,
  output logic [DW-1:0]      MEM_IDATA,
  input  logic [DW-1:0]      MEM_ODATA
);
  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q,  addr_d;
  logic           we_q,    we_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           id_q,    id_d;
  logic           adv;
  logic [1:0]     gnt;
  logic           win;
  logic [NBANK-1:0] sel_n;

  assign adv = !RST &&
    (state_q == S_IDLE || state_q == S_DONE);

  sram64kb_rr_arb u_arb (
    .CLK (CLK),
    .RST (RST),
    .req ({REQ1, REQ0}),
    .adv (adv),
    .gnt (gnt),
    .id  (win)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    id_d    = id_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (|gnt) begin
          state_d = S_SETUP;
          addr_d  = win ? ADDR1  : ADDR0;
          we_d    = win ? WE1    : WE0;
          wdata_d = win ? WDATA1 : WDATA0;
          id_d    = win;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        state_d = S_DONE;
        if (!we_q) rdata_d = MEM_ODATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_n   = bank_sel_n(addr_q[AW-1:BANK_AW]);
    MEM_CE  = 1'b0;
    MEM_WEB = 1'b1;
    MEM_CSB = '1;
    MEM_OEB = '1;
    DONE0   = 1'b0;
    DONE1   = 1'b0;
    BUSY    = (state_q != S_IDLE);
    unique case (state_q)
      S_SETUP, S_STROBE, S_HOLD: begin
        MEM_CE  = (state_q == S_STROBE);
        MEM_WEB = ~we_q;
        MEM_CSB = sel_n;
        if (!we_q) MEM_OEB = sel_n;
      end
      S_DONE: begin
        DONE0 = ~id_q;
        DONE1 = id_q;
      end
      default: ;
    endcase
  end

  assign GNT0      = gnt[0];
  assign GNT1      = gnt[1];
  assign RDATA     = rdata_q;
  assign MEM_ADDR  = addr_q[BANK_AW-1:0];
  assign MEM_IDATA = wdata_q;
endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Directed bench for sram64kb_ctrl with a behavioural 64-bank array model.
module tb_sram64kb_ctrl;
  logic        CLK;
  logic        RST;
  logic        REQ0, REQ1, WE0, WE1;
  logic [15:0] ADDR0, ADDR1;
  logic [7:0]  WDATA0, WDATA1;
  logic        GNT0, GNT1, DONE0, DONE1, BUSY;
  logic [7:0]  RDATA;
  logic [9:0]  MEM_ADDR;
  logic        MEM_CE, MEM_WEB;
  logic [63:0] MEM_OEB, MEM_CSB;
  logic [7:0]  MEM_IDATA, MEM_ODATA;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] last_rd;

  sram64kb_ctrl dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1),
    .DONE0(DONE0), .DONE1(DONE1),
    .RDATA(RDATA), .BUSY(BUSY),
    .MEM_ADDR(MEM_ADDR), .MEM_CE(MEM_CE),
    .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB),
    .MEM_CSB(MEM_CSB), .MEM_IDATA(MEM_IDATA),
    .MEM_ODATA(MEM_ODATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Array model: samples on the clock edge that ends the CE cycle.
  logic [7:0] mem [0:65535];
  logic [7:0] dout_q;
  logic [5:0] cs_bank;
  logic       cs_any;

  always_comb begin
    cs_bank = '0;
    cs_any  = 1'b0;
    for (int i = 0; i < 64; i++)
      if (!MEM_CSB[i]) begin
        cs_bank = 6'(i);
        cs_any  = 1'b1;
      end
  end

  always @(posedge CLK)
    if (MEM_CE && cs_any) begin
      if (!MEM_WEB) mem[{cs_bank, MEM_ADDR}] <= MEM_IDATA;
      else          dout_q <= mem[{cs_bank, MEM_ADDR}];
    end

  assign MEM_ODATA =
    (cs_any && !MEM_OEB[cs_bank]) ? dout_q : 8'h00;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic access(input int p, input logic we,
                        input logic [15:0] a,
                        input logic [7:0] wd,
                        input logic [7:0] exp_rd,
                        input logic exact,
                        output logic [7:0] rd);
    logic [63:0] sel;
    sel = ~(64'd1 << a[15:10]);
    @(posedge CLK); #1;
    if (p == 0) begin
      REQ0 = 1; WE0 = we; ADDR0 = a; WDATA0 = wd;
    end else begin
      REQ1 = 1; WE1 = we; ADDR1 = a; WDATA1 = wd;
    end
    @(negedge CLK);
    chk("gnt", (p == 0) ? GNT0 : GNT1, 1);
    @(posedge CLK); #1;
    REQ0 = 0; REQ1 = 0;
    ADDR0 = ~a; ADDR1 = ~a;
    WDATA0 = ~wd; WDATA1 = ~wd;
    @(negedge CLK);
    chk("setup_csb", MEM_CSB, sel);
    chk("setup_web", MEM_WEB, !we);
    chk("setup_oeb", MEM_OEB, we ? '1 : sel);
    chk("setup_addr", MEM_ADDR, a[9:0]);
    chk("setup_ce", MEM_CE, 0);
    chk("busy", BUSY, 1);
    if (we) chk("setup_idata", MEM_IDATA, wd);
    @(negedge CLK);
    chk("strobe_ce", MEM_CE, 1);
    chk("strobe_csb", MEM_CSB, sel);
    @(negedge CLK);
    chk("hold_ce", MEM_CE, 0);
    chk("hold_csb", MEM_CSB, sel);
    @(negedge CLK);
    chk("done", (p == 0) ? DONE0 : DONE1, 1);
    chk("done_other", (p == 0) ? DONE1 : DONE0, 0);
    chk("done_csb", MEM_CSB, '1);
    chk("done_oeb", MEM_OEB, '1);
    chk("done_web", MEM_WEB, 1);
    chk("done_addr", MEM_ADDR, a[9:0]);
    rd = RDATA;
    if (we) chk("rd_keep", RDATA, last_rd);
    else if (exact) begin
      chk("rdata", RDATA, exp_rd);
      last_rd = exp_rd;
    end
  endtask

  logic [7:0] rd;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    dout_q = 8'h00;
    last_rd = 8'h00;
    RST = 1; REQ0 = 1; REQ1 = 0; WE0 = 0; WE1 = 0;
    ADDR0 = 16'h0400; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;

    repeat (3) begin
      @(negedge CLK);
      chk("rst_gnt0", GNT0, 0);
    end
    chk("rst_done", {DONE0, DONE1}, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_ce", MEM_CE, 0);
    chk("rst_web", MEM_WEB, 1);
    chk("rst_csb", MEM_CSB, '1);
    chk("rst_oeb", MEM_OEB, '1);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_idata", MEM_IDATA, 0);
    @(posedge CLK); #1;
    RST = 0; REQ0 = 0;

    access(0, 1, 16'h0400, 8'hA5, 0, 0, rd);
    access(0, 0, 16'h0400, 0, 8'hA5, 1, rd);

    access(0, 1, 16'h0000, 8'h11, 0, 0, rd);
    access(1, 1, 16'hFFFF, 8'h22, 0, 0, rd);
    access(0, 0, 16'h0000, 0, 8'h11, 1, rd);
    access(1, 0, 16'hFFFF, 0, 8'h22, 1, rd);

    access(0, 0, 16'h0400, 0, 8'hA5, 1, rd);
    access(1, 1, 16'h0800, 8'h77, 0, 0, rd);

    // Reset during the strobe cycle of a write.
    @(posedge CLK); #1;
    REQ0 = 1; WE0 = 1; ADDR0 = 16'h1234; WDATA0 = 8'h5A;
    @(negedge CLK);
    chk("mid_gnt", GNT0, 1);
    @(posedge CLK); #1;
    REQ0 = 0;
    @(posedge CLK); #1;
    RST = 1;
    @(negedge CLK);
    chk("mid_ce", MEM_CE, 1);
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    chk("mid_ce_off", MEM_CE, 0);
    chk("mid_csb", MEM_CSB, '1);
    chk("mid_oeb", MEM_OEB, '1);
    chk("mid_busy", BUSY, 0);
    chk("mid_done", {DONE0, DONE1}, 0);
    @(negedge CLK);
    chk("mid_done2", {DONE0, DONE1}, 0);
    chk("mid_rdata", RDATA, 0);
    last_rd = 8'h00;
    access(1, 0, 16'h1234, 0, 0, 0, rd);
    chk("mid_rd_ok", (rd === 8'h5A) || (rd === 8'h00), 1);

    // Both ports contend for four back-to-back reads.
    @(posedge CLK); #1;
    REQ0 = 1; REQ1 = 1; WE0 = 0; WE1 = 0;
    ADDR0 = 16'h0400; ADDR1 = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      @(negedge CLK);
      if (k == 13) begin
        REQ0 = 0; REQ1 = 0;
      end
      if (k % 4 == 0) begin
        if (k <= 12) begin
          chk("rr_gnt0", GNT0, ((k / 4) % 2) == 0);
          chk("rr_gnt1", GNT1, ((k / 4) % 2) == 1);
        end else begin
          chk("rr_gnt_end", {GNT0, GNT1}, 0);
        end
        if (k > 0) begin
          chk("rr_done0", DONE0, (((k / 4) - 1) % 2) == 0);
          chk("rr_done1", DONE1, (((k / 4) - 1) % 2) == 1);
          chk("rr_rdata", RDATA,
              ((((k / 4) - 1) % 2) == 0) ? 8'hA5 : 8'h22);
        end
      end else begin
        chk("rr_nodone", {DONE0, DONE1}, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
